// File: rtl/bench_result_reporter_pkg.sv
// Shared definitions for bench_result_reporter: ASCII constants, frame length,
// FSM states and the nibble-to-hex helper.
// Optional feature macro: BENCH_REPORT_CRLF_EN (terminator "\r\n" instead of "\n").
package bench_result_reporter_pkg;

  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

`ifdef BENCH_REPORT_CRLF_EN
  localparam int unsigned FRAME_LEN = 40;
`else
  localparam int unsigned FRAME_LEN = 39;
`endif

  localparam int unsigned IDX_W = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_FETCH,
    ST_XMIT
  } state_t;

  // Uppercase hex digit for a 4-bit value
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return ASCII_0 + {4'h0, n};
    else           return ASCII_A + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/bench_result_reporter_uart_tx_byte.sv
// UART 8N1 byte transmitter: baud counter plus start/data/stop shifter.
// done_pulse is high during the final cycle of the stop bit.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done_pulse
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [8:0]       shreg;     // {stop, d7..d0}, shifted out LSB first
  logic             active;

  assign done_pulse = active && (bit_idx == 4'd9) && (cnt == CNT_LAST);

  // Bit timing and shifting; tx is registered so it is glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 1'b1;
      active  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '1;
    end else if (load) begin
      tx      <= 1'b0;
      shreg   <= {1'b1, data};
      active  <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
    end else if (active) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bench_result_reporter.sv
// Bench result reporter: snapshots bench results on done and prints them as
// one ASCII line ("W<n> XXXXXXXX x4" + terminator) over UART 8N1.
// Optional feature macro: BENCH_REPORT_CRLF_EN (CR LF terminator, 40-byte frame).
module bench_result_reporter
  import bench_result_reporter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done,
  input  logic [31:0] t_cond0,
  input  logic [31:0] t_cond1,
  input  logic [31:0] t_cond2,
  input  logic [31:0] t_cond3,
  input  logic [1:0]  winner_code,
  output logic        uart_tx,
  output logic        busy,
  output logic [15:0] frames_sent,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t           state, next_state;
  logic [IDX_W-1:0] idx;
  logic [31:0]      snap_t [4];
  logic [1:0]       snap_win;
  logic [7:0]       cur_char;
  logic             load;
  logic             byte_done;
  logic             last_byte;

  assign last_byte = (idx == LAST_IDX);

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (cur_char),
    .tx         (uart_tx),
    .done_pulse (byte_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next state, byte load strobe and busy flag
  always_comb begin
    next_state = state;
    load       = 1'b0;
    busy       = (state != ST_IDLE);
    unique case (state)
      ST_IDLE:    if (done) next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = ST_FETCH;
      ST_FETCH: begin
        load       = 1'b1;
        next_state = ST_XMIT;
      end
      ST_XMIT:    if (byte_done) next_state = last_byte ? ST_IDLE : ST_FETCH;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Snapshot of results, taken only on an accepted done
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) snap_t[i] <= '0;
      snap_win <= '0;
    end else if (state == ST_IDLE && done) begin
      snap_t[0] <= t_cond0;
      snap_t[1] <= t_cond1;
      snap_t[2] <= t_cond2;
      snap_t[3] <= t_cond3;
      snap_win  <= winner_code;
    end
  end

  // Byte index and frame/drop counters
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      frames_sent <= '0;
      drop_cnt    <= '0;
    end else begin
      if (state == ST_CAPTURE) idx <= '0;
      else if (state == ST_XMIT && byte_done && !last_byte) idx <= idx + 1'b1;

      if (state == ST_XMIT && byte_done && last_byte) frames_sent <= frames_sent + 16'd1;

      if (done && busy && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Character at the current byte index: W, winner, 4 x (space + 8 hex), terminator
  always_comb begin
    cur_char = ASCII_LF;
    if (idx == '0) cur_char = ASCII_W;
    else if (idx == IDX_W'(1)) cur_char = ASCII_0 + {6'b0, snap_win};
    for (int unsigned g = 0; g < 4; g++) begin
      if (idx == IDX_W'(2 + 9 * g)) cur_char = ASCII_SP;
      for (int unsigned k = 0; k < 8; k++) begin
        if (idx == IDX_W'(3 + 9 * g + k)) cur_char = hex_char(snap_t[g][(7 - k) * 4 +: 4]);
      end
    end
`ifdef BENCH_REPORT_CRLF_EN
    if (idx == IDX_W'(FRAME_LEN - 2)) cur_char = ASCII_CR;
`endif
  end

endmodule

// File: tb/tb_bench_result_reporter.sv
// Self-checking bench for bench_result_reporter (10 clocks per UART bit).
module tb_bench_result_reporter;

  localparam int CPB = 10;
`ifdef BENCH_REPORT_CRLF_EN
  localparam int FLEN = 40;
`else
  localparam int FLEN = 39;
`endif
  localparam int BUSY_LEN = 1 + FLEN * (1 + 10 * CPB);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done = 1'b0;
  logic [31:0] t_cond0 = '0, t_cond1 = '0, t_cond2 = '0, t_cond3 = '0;
  logic [1:0]  winner_code = '0;
  logic        uart_tx;
  logic        busy;
  logic [15:0] frames_sent;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;
  logic [7:0] rx_q[$];
  int rx_ferr = 0;
  int m_frames = 0;
  int m_drops = 0;

  bench_result_reporter #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk         (clk),
    .rst         (rst),
    .done        (done),
    .t_cond0     (t_cond0),
    .t_cond1     (t_cond1),
    .t_cond2     (t_cond2),
    .t_cond3     (t_cond3),
    .winner_code (winner_code),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .frames_sent (frames_sent),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART receiver: samples mid-bit on falling clock edges; bytes overlapping reset are discarded
  initial begin : rx_mon
    logic [7:0] b;
    bit bad;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        bad = 1'b0;
        b = '0;
        for (int s = 1; s <= 95; s++) begin
          @(negedge clk);
          if (rst) bad = 1'b1;
          if (s >= 15 && s <= 85 && (s - 5) % 10 == 0) b[(s - 15) / 10] = uart_tx;
          if (s == 95 && uart_tx !== 1'b1 && !bad) rx_ferr++;
        end
        if (!bad) rx_q.push_back(b);
      end
    end
  end

  // Expected line built from the formatting rules, compared against received bytes
  task automatic compare_frame(input logic [31:0] a, b, c, d, input logic [1:0] w, input string name);
    string s;
    logic [31:0] got;
    s = $sformatf("W%0d %08h %08h %08h %08h", w, a, b, c, d);
    s = s.toupper();
`ifdef BENCH_REPORT_CRLF_EN
    s = {s, "\r\n"};
`else
    s = {s, "\n"};
`endif
    check({name, " len"}, 32'(rx_q.size()), 32'(s.len()));
    for (int i = 0; i < s.len(); i++) begin
      got = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD;
      check($sformatf("%s byte%0d", name, i), got, 32'(s[i]));
    end
    rx_q.delete();
  endtask

  // Drives one done pulse (called at a falling edge) and follows the frame until busy drops.
  // mode: 0 none, 1 done in byte 10, 2 300 pulses, 3 done in final stop cycle, 4 reset in byte 5
  task automatic send_frame(input logic [31:0] a, b, c, d, input logic [1:0] w,
                            input int mode, output int busy_len);
    bit pulse;
    t_cond0 = a; t_cond1 = b; t_cond2 = c; t_cond3 = d; winner_code = w;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    busy_len = 0;
    while (busy === 1'b1 && busy_len < 6000) begin
      busy_len++;
      t_cond0 = $urandom(); t_cond1 = $urandom(); t_cond2 = $urandom(); t_cond3 = $urandom();
      winner_code = 2'($urandom_range(0, 3));
      if (mode == 4 && busy_len == 1 + 5 * 101 + 30) begin
        rst = 1'b1;
        @(negedge clk);
        check("rst uart_tx", 32'(uart_tx), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst frames", 32'(frames_sent), 32'd0);
        check("rst drops", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        m_frames = 0;
        m_drops = 0;
        return;
      end
      pulse = (mode == 1 && busy_len == 1 + 10 * 101 + 3) ||
              (mode == 2 && busy_len >= 2 && busy_len < 302) ||
              (mode == 3 && busy_len == BUSY_LEN);
      done = pulse;
      if (pulse && m_drops < 255) m_drops++;
      @(negedge clk);
    end
    done = 1'b0;
    if (busy_len >= 6000) check("busy timeout", 32'(busy), 32'd0);
    m_frames = (m_frames + 1) % 65536;
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int len;
    logic [31:0] r0, r1, r2, r3;
    logic [1:0] rw;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset uart_tx", 32'(uart_tx), 32'd1);
      check("reset busy", 32'(busy), 32'd0);
      check("reset frames", 32'(frames_sent), 32'd0);
      check("reset drops", 32'(drop_cnt), 32'd0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle uart_tx", 32'(uart_tx), 32'd1);

    // Known frame
    send_frame(32'h00000012, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 2'd3, 0, len);
    check("f1 busy_len", 32'(len), 32'(BUSY_LEN));
    compare_frame(32'h00000012, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 2'd3, "f1");
    check("f1 frames", 32'(frames_sent), 32'(m_frames));
    check("f1 drops", 32'(drop_cnt), 32'(m_drops));

    // Same frame with inputs scrambled after capture and a done mid-frame
    send_frame(32'h00000012, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 2'd3, 1, len);
    check("f2 busy_len", 32'(len), 32'(BUSY_LEN));
    compare_frame(32'h00000012, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 2'd3, "f2");
    check("f2 frames", 32'(frames_sent), 32'(m_frames));
    check("f2 drops", 32'(drop_cnt), 32'(m_drops));

    // Random frame with done in the last stop-bit cycle
    r0 = $urandom(); r1 = $urandom(); r2 = $urandom(); r3 = $urandom(); rw = 2'($urandom_range(0, 3));
    send_frame(r0, r1, r2, r3, rw, 3, len);
    check("f3 busy_len", 32'(len), 32'(BUSY_LEN));
    compare_frame(r0, r1, r2, r3, rw, "f3");
    check("f3 frames", 32'(frames_sent), 32'(m_frames));
    check("f3 drops", 32'(drop_cnt), 32'(m_drops));

    // Back-to-back random frame with 300 dropped pulses (saturation)
    r0 = $urandom(); r1 = $urandom(); r2 = $urandom(); r3 = $urandom(); rw = 2'($urandom_range(0, 3));
    send_frame(r0, r1, r2, r3, rw, 2, len);
    check("f4 busy_len", 32'(len), 32'(BUSY_LEN));
    compare_frame(r0, r1, r2, r3, rw, "f4");
    check("f4 frames", 32'(frames_sent), 32'(m_frames));
    check("f4 drops", 32'(drop_cnt), 32'(m_drops));

    // Reset during byte 5
    r0 = $urandom(); r1 = $urandom(); r2 = $urandom(); r3 = $urandom(); rw = 2'($urandom_range(0, 3));
    send_frame(r0, r1, r2, r3, rw, 4, len);
    repeat (120) @(negedge clk);
    check("post-rst uart_tx", 32'(uart_tx), 32'd1);
    check("post-rst busy", 32'(busy), 32'd0);
    rx_q.delete();

    // Fresh frames after reset
    r0 = $urandom(); r1 = $urandom(); r2 = $urandom(); r3 = $urandom(); rw = 2'($urandom_range(0, 3));
    send_frame(r0, r1, r2, r3, rw, 0, len);
    check("f5 busy_len", 32'(len), 32'(BUSY_LEN));
    compare_frame(r0, r1, r2, r3, rw, "f5");
    check("f5 frames", 32'(frames_sent), 32'(m_frames));
    check("f5 drops", 32'(drop_cnt), 32'(m_drops));

    r0 = $urandom(); r1 = $urandom(); r2 = $urandom(); r3 = $urandom(); rw = 2'($urandom_range(0, 3));
    send_frame(r0, r1, r2, r3, rw, 1, len);
    check("f6 busy_len", 32'(len), 32'(BUSY_LEN));
    compare_frame(r0, r1, r2, r3, rw, "f6");
    check("f6 frames", 32'(frames_sent), 32'(m_frames));
    check("f6 drops", 32'(drop_cnt), 32'(m_drops));

    repeat (20) @(negedge clk);
    check("rx framing errors", 32'(rx_ferr), 32'd0);
    check("no stray bytes", 32'(rx_q.size()), 32'd0);
    check("final uart_tx", 32'(uart_tx), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
